// File: rtl/multiword_add_ctrl_pkg.sv
// Shared definitions for multiword_add_ctrl: FSM state encodings and the
// counter-width helper.
package multiword_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns ceil(log2(value)) but never less than 1, so a single-word
  // configuration still gets a one-bit counter.
  function automatic int clog2Min1(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder shared by the multiword sequencer; one word
// of the wide operation passes through it per cycle.
module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  logic w_ripple;

  // A single running carry variable avoids a self-referencing carry vector.
  always_comb begin
    w_ripple = i_carry;
    o_sum    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_ripple;
      w_ripple = (i_a[i] & i_b[i]) | (w_ripple & (i_a[i] ^ i_b[i]));
    end
    o_carry = w_ripple;
  end

endmodule

// File: rtl/multiword_add_ctrl.sv
// Wide add/subtract sequencer that time-multiplexes one WIDTH-bit adder,
// least-significant word first. Define ADDER_CTRL_SUB_EN to enable subtraction.
import multiword_add_ctrl_pkg::*;

module multiword_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   carry_in,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   carry_out,
  output logic                   busy
);

  localparam int N  = WIDTH * WORDS;
  localparam int CW = clog2Min1(WORDS);
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [N-1:0]     r_opA;
  logic [N-1:0]     r_opB;
  logic [N-1:0]     r_result;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_wordA;
  logic [WIDTH-1:0] w_wordB;
  logic [WIDTH-1:0] w_sumWord;
  logic             w_carryOut;
  logic             w_lastWord;

  assign w_lastWord = (r_count == LAST_WORD);
  assign w_wordA    = r_opA[int'(r_count)*WIDTH +: WIDTH];

`ifdef ADDER_CTRL_SUB_EN
  logic r_sub;
  assign w_wordB = r_opB[int'(r_count)*WIDTH +: WIDTH] ^ {WIDTH{r_sub}};
`else
  logic w_unusedSub;
  assign w_unusedSub = sub;
  assign w_wordB     = r_opB[int'(r_count)*WIDTH +: WIDTH];
`endif

  ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
    .i_a     (w_wordA),
    .i_b     (w_wordB),
    .i_carry (r_carry),
    .o_sum   (w_sumWord),
    .o_carry (w_carryOut)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (in_valid)   w_nextState = RUN;
      RUN:     if (w_lastWord) w_nextState = DONE;
      DONE:    if (out_ready)  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Operands are captured on accept; each RUN cycle retires one result word
  // and forwards its carry to the next word through r_carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opA    <= '0;
      r_opB    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_count  <= '0;
`ifdef ADDER_CTRL_SUB_EN
      r_sub    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_opA   <= a;
            r_opB   <= b;
            r_count <= '0;
`ifdef ADDER_CTRL_SUB_EN
            r_sub   <= sub;
            r_carry <= carry_in | sub;
`else
            r_carry <= carry_in;
`endif
          end
        end
        RUN: begin
          r_result[int'(r_count)*WIDTH +: WIDTH] <= w_sumWord;
          r_carry <= w_carryOut;
          if (!w_lastWord) r_count <= r_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN) || (r_state == DONE);
  assign sum       = r_result;
  assign carry_out = r_carry;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Scoreboard bench for multiword_add_ctrl (WIDTH=8, WORDS=4): directed vectors
// push hand-computed results, a negedge monitor pops and compares them.
module tb_multiword_add_ctrl;

   localparam int WIDTH = 8;
   localparam int WORDS = 4;
   localparam int N     = WIDTH * WORDS;

   typedef struct {
      logic [N-1:0] sum;
      logic         cout;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         carry_in;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] sum;
   logic         carry_out;
   logic         busy;

   exp_t expQ[$];
   exp_t popped;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   lastAccept = -1;
   int   prevAccept = -1;
   logic prevValid = 1'b0;

   multiword_add_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .busy      (busy)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Hard stop in case some bounded wait is ever mis-sized.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Waits for in_ready, presents one operand set for a single accept cycle
   // and queues the hand-computed result.
   task automatic applyStimulus(input logic [N-1:0] opA, input logic [N-1:0] opB,
                                input logic cin, input logic doSub,
                                input logic [N-1:0] expSum, input logic expCout);
      int guard;
      exp_t item;
      guard = 0;
      @(posedge clk); #1;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("[TB] FAIL in_ready wait: actual=0 required=1");
      end else begin
         a        = opA;
         b        = opB;
         carry_in = cin;
         sub      = doSub;
         in_valid = 1'b1;
         item.sum  = expSum;
         item.cout = expCout;
         expQ.push_back(item);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   // Bounded wait until the monitor has consumed every queued result.
   task automatic waitDrain();
      int guard;
      guard = 0;
      while (expQ.size() != 0 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      checkOutput("queue drained", 64'(expQ.size()), 64'd0);
   endtask

   // Monitor: tracks accept cycles, checks latency on the rising edge of
   // out_valid and scores every completed output handshake.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         prevValid = 1'b0;
      end else begin
         if (in_valid && in_ready) begin
            prevAccept = lastAccept;
            lastAccept = cyc;
         end
         if (out_valid && !prevValid)
            checkOutput("latency", 64'(cyc - lastAccept), 64'(WORDS + 1));
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected result: actual=%0h required=none", sum);
            end else begin
               popped = expQ.pop_front();
               checkOutput("sum", 64'(sum), 64'(popped.sum));
               checkOutput("carry_out", 64'(carry_out), 64'(popped.cout));
            end
         end
         prevValid = out_valid;
      end
   end

   initial begin
      int guard;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      carry_in  = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;

      #12;
      checkOutput("reset in_ready", 64'(in_ready), 64'd1);
      checkOutput("reset out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset sum", 64'(sum), 64'd0);
      checkOutput("reset carry_out", 64'(carry_out), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      $display("[TB] carry across words and overflow");
      applyStimulus(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0);
      waitDrain();
      applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1);
      waitDrain();
      applyStimulus(32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 32'h00010000, 1'b0);
      waitDrain();

`ifdef ADDER_CTRL_SUB_EN
      $display("[TB] subtraction");
      applyStimulus(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0);
      waitDrain();
      applyStimulus(32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1);
      waitDrain();
`else
      $display("[TB] sub input ignored in add-only build");
      applyStimulus(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'h0000000C, 1'b0);
      waitDrain();
      applyStimulus(32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h0000000C, 1'b0);
      waitDrain();
`endif

      $display("[TB] backpressure");
      out_ready = 1'b0;
      applyStimulus(32'h00000010, 32'h00000020, 1'b0, 1'b0, 32'h00000030, 1'b0);
      guard = 0;
      while (!out_valid && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      checkOutput("bp reached DONE", 64'(out_valid), 64'd1);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            a        = 32'h0000DEAD;
            b        = 32'h0000BEEF;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         checkOutput("bp sum held", 64'(sum), 64'h30);
         checkOutput("bp in_ready low", 64'(in_ready), 64'd0);
         checkOutput("bp out_valid held", 64'(out_valid), 64'd1);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp back to idle", 64'(in_ready), 64'd1);
      checkOutput("bp out_valid dropped", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("bp pulse ignored", 64'(busy), 64'd0);
      waitDrain();

      $display("[TB] reset mid-run");
      applyStimulus(32'hAAAAAAAA, 32'h11111111, 1'b0, 1'b0, 32'hBBBBBBBB, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("pre-reset busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      expQ.delete();
      checkOutput("mid reset in_ready", 64'(in_ready), 64'd1);
      checkOutput("mid reset out_valid", 64'(out_valid), 64'd0);
      checkOutput("mid reset busy", 64'(busy), 64'd0);
      checkOutput("mid reset sum", 64'(sum), 64'd0);
      checkOutput("mid reset carry_out", 64'(carry_out), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("post reset in_ready", 64'(in_ready), 64'd1);
      applyStimulus(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0);
      waitDrain();

      $display("[TB] back-to-back");
      applyStimulus(32'h01020304, 32'h10203040, 1'b0, 1'b0, 32'h11223344, 1'b0);
      applyStimulus(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1);
      waitDrain();
      checkOutput("accept spacing", 64'(lastAccept - prevAccept), 64'(WORDS + 2));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
